// File: rtl/if_fetch_stage.sv
// if_fetch_stage: LEGv8 instruction fetch stage.
// Holds the PC, issues one outstanding request at a time to instruction
// memory, buffers one instruction toward decode and honours branch redirects.
// Wrong-path requests are never withdrawn; they complete in DRAIN and their
// data is dropped.
// Optional build macro IF_PERF_CNT_EN adds saturating perf counters
// perf_fetched and perf_stall.
//
// Handshakes: decode takes the buffered instruction on a cycle where
// if_valid && if_ready (and no redirect); memory completes a request on a
// cycle where imem_req && imem_ack. imem_req/imem_addr never change while a
// request is outstanding, and imem_ack with imem_req low is ignored.
// dbg_state exposes the FSM state (IDLE=0, REQ=1, FULL=2, DRAIN=3).
module if_fetch_stage #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [10:0]     if_opcode,
  output logic [PC_W-1:0] if_pc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
`endif
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [PC_W-1:0] addr_q;
  logic            valid_q, valid_n;
  logic            capture;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;

  // Redirect targets are forced word aligned; sequential PC wraps silently.
  assign target = redirect_pc & ~PC_W'(3);
  assign pc_inc = pc + PC_W'(4);

  // State, PC and instruction buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      valid_q  <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      valid_q <= valid_n;
      if (capture) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
      end
    end
  end

  // Remember the address of the request being issued so DRAIN can keep
  // presenting it after a redirect has already moved the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= RESET_PC;
    end else if (state == S_REQ) begin
      addr_q <= pc;
    end
  end

  // Next-state logic; redirect outranks every other event outside IDLE.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = valid_q;
    capture = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_n = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          pc_n    = target;
          state_n = imem_ack ? S_REQ : S_DRAIN;
        end else if (imem_ack) begin
          capture = 1'b1;
          valid_n = 1'b1;
          pc_n    = pc_inc;
          state_n = S_FULL;
        end
      end
      S_FULL: begin
        if (redirect) begin
          pc_n    = target;
          valid_n = 1'b0;
          state_n = S_REQ;
        end else if (if_ready) begin
          valid_n = 1'b0;
          state_n = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect) pc_n = target;
        if (imem_ack) state_n = S_REQ;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign imem_req  = (state == S_REQ) || (state == S_DRAIN);
  assign imem_addr = (state == S_DRAIN) ? addr_q : pc;
  assign if_valid  = valid_q;
  assign if_opcode = if_instr[31:21];
  assign dbg_state = state;

`ifdef IF_PERF_CNT_EN
  logic fetched_ev;
  logic stall_ev;

  assign fetched_ev = valid_q && if_ready && !redirect;
  assign stall_ev   = (imem_req && !imem_ack) || ((state == S_FULL) && !if_ready);

  // Saturating event counters for accepted instructions and stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fetched_ev && (perf_fetched != 32'hFFFF_FFFF)) perf_fetched <= perf_fetched + 32'd1;
      if (stall_ev && (perf_stall != 32'hFFFF_FFFF))     perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
